// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared PC-source encodings, default vectors, FSM states and PC alignment helper
package pc_sequencer_pkg;
   localparam logic [31:0] DEF_RESET_VEC   = 32'h0000_0000;
   localparam logic [31:0] DEF_HANDLER_VEC = 32'h0000_0180;
   typedef enum logic [1:0] {PCSRC_SEQ = 2'd0, PCSRC_BR = 2'd1, PCSRC_JMP = 2'd2, PCSRC_EXC = 2'd3} pcsrc_t;
   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HANDLER = 2'd2} state_t;
   function automatic logic [31:0] align_pc(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: MEM-stage redirect inputs and IF-side PC/flush/exception outputs of the sequencer
//   master: MEM/IF side (drives stall, PCSource, targets, eret; observes PC, fetch_en, flushes, EPC, status)
//   slave : pc_sequencer (the reverse)
interface pc_sequencer_if;
   logic        stall;
   logic [1:0]  PCSource;
   logic [31:0] PC_branch;
   logic [31:0] PC_jump;
   logic [31:0] PC_exc;
   logic        eret;
   logic [31:0] PC;
   logic        fetch_en;
   logic        flush_IF;
   logic        flush_ID;
   logic        flush_EX;
   logic [31:0] EPC;
   logic        in_handler;
   logic        exc_lost;
   modport master (
      output stall, PCSource, PC_branch, PC_jump, PC_exc, eret,
      input  PC, fetch_en, flush_IF, flush_ID, flush_EX, EPC, in_handler, exc_lost
   );
   modport slave (
      input  stall, PCSource, PC_branch, PC_jump, PC_exc, eret,
      output PC, fetch_en, flush_IF, flush_ID, flush_EX, EPC, in_handler, exc_lost
   );
endinterface

// File: rtl/pc_sequencer_drain_counter.sv
// pc_drain_counter: loadable down-counter with a done flag (count == 0)
//   clk, rst_n : clock, async active-low reset
//   i_load/i_load_val : load the count (wins over decrement)
//   i_dec      : decrement by one
//   o_done     : count is zero
module pc_drain_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_done
);
   logic [W-1:0] r_cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_cnt <= '0;
      else r_cnt <= i_load ? i_load_val : i_dec ? r_cnt - 1'b1 : r_cnt;
   assign o_done = r_cnt == '0;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register sequencing seq/branch/jump/exception, pipeline flushes, fetch drain, EPC and ERET
//   clk, rst_n : clock, async active-low reset
//   bus        : pc_sequencer_if.slave (MEM redirect inputs in, PC/fetch_en/flush_*/EPC/in_handler/exc_lost out)
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_VEC    = DEF_RESET_VEC,
   parameter logic [31:0] HANDLER_VEC  = DEF_HANDLER_VEC,
   parameter int          DRAIN_CYCLES = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   pc_sequencer_if.slave  bus
);
   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, r_epc, w_pc_nxt, w_epc_nxt;
   logic        r_fetch, r_flush, r_inh, r_lost;
   logic        w_fetch_nxt, w_flush_nxt, w_inh_nxt, w_lost_nxt;
   logic        w_exc, w_take_exc, w_take_eret, w_active, w_jmp, w_br, w_done, w_drain_end;
   assign w_exc       = bus.PCSource == PCSRC_EXC;
   assign w_take_exc  = r_state == RUN && w_exc;
   assign w_take_eret = r_state == HANDLER && bus.eret;
   assign w_drain_end = r_state == DRAIN && w_done;
   // DRAIN ignores every MEM input: those instructions were already flushed
   assign w_active    = r_state != DRAIN;
   assign w_jmp       = w_active && bus.PCSource == PCSRC_JMP;
   assign w_br        = w_active && bus.PCSource == PCSRC_BR;
   pc_drain_counter #(.W(4)) u_drain (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_take_exc),
      .i_load_val (4'(DRAIN_CYCLES - 1)),
      .i_dec      (r_state == DRAIN && !w_done),
      .o_done     (w_done)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= RUN;
         r_pc    <= RESET_VEC;
         r_epc   <= '0;
         r_fetch <= 1'b1;
         r_flush <= 1'b0;
         r_inh   <= 1'b0;
         r_lost  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_epc   <= w_epc_nxt;
         r_fetch <= w_fetch_nxt;
         r_flush <= w_flush_nxt;
         r_inh   <= w_inh_nxt;
         r_lost  <= w_lost_nxt;
      end
   always_comb
      w_state_nxt = w_take_exc ? DRAIN : w_take_eret ? RUN : w_drain_end ? HANDLER : r_state;
   // an exception inside the handler is dropped (flagged) and behaves like a sequential step
   always_comb begin
      w_pc_nxt    = w_take_exc  ? align_pc(HANDLER_VEC) :
                    w_take_eret ? align_pc(r_epc) :
                    w_jmp       ? align_pc(bus.PC_jump) :
                    w_br        ? align_pc(bus.PC_branch) :
                    (!w_active || bus.stall) ? r_pc : r_pc + 32'd4;
      w_flush_nxt = w_take_exc || w_take_eret || w_jmp || w_br;
      w_epc_nxt   = w_take_exc ? bus.PC_exc : r_epc;
      w_fetch_nxt = w_take_exc ? 1'b0 : w_drain_end ? 1'b1 : r_fetch;
      w_inh_nxt   = w_take_exc ? 1'b1 : w_take_eret ? 1'b0 : r_inh;
      w_lost_nxt  = r_lost || (r_state == HANDLER && !bus.eret && w_exc);
   end
   assign bus.PC         = r_pc;
   assign bus.EPC        = r_epc;
   assign bus.fetch_en   = r_fetch;
   assign bus.flush_IF   = r_flush;
   assign bus.flush_ID   = r_flush;
   assign bus.flush_EX   = r_flush;
   assign bus.in_handler = r_inh;
   assign bus.exc_lost   = r_lost;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector bench for pc_sequencer with hand-computed expectations
module tb_pc_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   pc_sequencer_if bus();
   pc_sequencer #(.RESET_VEC(32'h0), .HANDLER_VEC(32'h180), .DRAIN_CYCLES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic [1:0] src, input logic st, input logic er);
      bus.PCSource = src;
      bus.stall    = st;
      bus.eret     = er;
   endtask
   function automatic logic [31:0] fl();
      return {29'd0, bus.flush_IF, bus.flush_ID, bus.flush_EX};
   endfunction
   initial begin
      bus.PC_branch = '0;
      bus.PC_jump   = '0;
      bus.PC_exc    = '0;
      drive(2'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", bus.PC, 32'h0);
      chk("rst_epc", bus.EPC, 32'h0);
      chk("rst_fetch", bus.fetch_en, 1);
      chk("rst_flush", fl(), 0);
      chk("rst_inh", bus.in_handler, 0);
      chk("rst_lost", bus.exc_lost, 0);
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("seq_pc", bus.PC, 32'(i * 4));
         chk("seq_flush", fl(), 0);
      end
      bus.PC_branch = 32'h103;
      drive(2'd1, 1'b1, 1'b0);
      step();
      chk("br_pc", bus.PC, 32'h100);
      chk("br_flush", fl(), 3'b111);
      drive(2'd0, 1'b0, 1'b0);
      step();
      chk("br_next_pc", bus.PC, 32'h104);
      chk("br_flush_end", fl(), 0);
      bus.PC_jump = 32'h40;
      drive(2'd2, 1'b0, 1'b0);
      step();
      chk("jmp_pc", bus.PC, 32'h40);
      chk("jmp_flush", fl(), 3'b111);
      bus.PC_exc = 32'h38;
      drive(2'd3, 1'b1, 1'b0);
      step();
      chk("exc_pc", bus.PC, 32'h180);
      chk("exc_epc", bus.EPC, 32'h38);
      chk("exc_fetch", bus.fetch_en, 0);
      chk("exc_inh", bus.in_handler, 1);
      chk("exc_flush", fl(), 3'b111);
      bus.PC_jump = 32'h500;
      drive(2'd2, 1'b0, 1'b1);
      step();
      chk("drain_pc", bus.PC, 32'h180);
      chk("drain_fetch", bus.fetch_en, 0);
      chk("drain_flush", fl(), 0);
      step();
      chk("drain_end_pc", bus.PC, 32'h180);
      chk("drain_end_fetch", bus.fetch_en, 1);
      chk("drain_end_inh", bus.in_handler, 1);
      drive(2'd3, 1'b0, 1'b0);
      step();
      chk("hnd_exc_pc", bus.PC, 32'h184);
      chk("hnd_exc_lost", bus.exc_lost, 1);
      chk("hnd_exc_flush", fl(), 0);
      drive(2'd0, 1'b0, 1'b0);
      step();
      chk("hnd_seq_pc", bus.PC, 32'h188);
      chk("hnd_lost_sticky", bus.exc_lost, 1);
      bus.PC_branch = 32'h900;
      drive(2'd1, 1'b1, 1'b1);
      step();
      chk("eret_pc", bus.PC, 32'h38);
      chk("eret_flush", fl(), 3'b111);
      chk("eret_inh", bus.in_handler, 0);
      drive(2'd0, 1'b0, 1'b0);
      step();
      chk("post_eret_pc", bus.PC, 32'h3c);
      chk("post_eret_flush", fl(), 0);
      drive(2'd0, 1'b0, 1'b1);
      step();
      chk("run_eret_pc", bus.PC, 32'h40);
      chk("run_eret_inh", bus.in_handler, 0);
      bus.PC_jump = 32'hFFFF_FFFF;
      drive(2'd2, 1'b0, 1'b0);
      step();
      chk("jmp_align_pc", bus.PC, 32'hFFFF_FFFC);
      drive(2'd0, 1'b0, 1'b0);
      step();
      chk("wrap_pc", bus.PC, 32'h0);
      drive(2'd0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_pc", bus.PC, 32'h0);
         chk("stall_flush", fl(), 0);
      end
      bus.PC_exc = 32'h77;
      drive(2'd3, 1'b0, 1'b0);
      step();
      chk("exc2_epc", bus.EPC, 32'h77);
      chk("exc2_fetch", bus.fetch_en, 0);
      drive(2'd0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pc", bus.PC, 32'h0);
      chk("arst_epc", bus.EPC, 32'h0);
      chk("arst_inh", bus.in_handler, 0);
      chk("arst_fetch", bus.fetch_en, 1);
      chk("arst_lost", bus.exc_lost, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post_rst_pc", bus.PC, 32'h4);
      chk("post_rst_fetch", bus.fetch_en, 1);
      bus.PC_exc = 32'h20;
      drive(2'd3, 1'b0, 1'b0);
      step();
      drive(2'd0, 1'b0, 1'b0);
      step();
      step();
      chk("h2_fetch", bus.fetch_en, 1);
      drive(2'd3, 1'b0, 1'b1);
      step();
      chk("eret_exc_pc", bus.PC, 32'h20);
      chk("eret_exc_lost", bus.exc_lost, 0);
      chk("eret_exc_inh", bus.in_handler, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
